// File: rtl/spectrum_bar_builder.sv
// spectrum_bar_builder
// Scans N magnitude bins one per clock on each frame request, takes the peak
// of each group of N/BARS consecutive bins, scales and saturates it into a bar
// height, and applies peak-hold with a linear decay of 1 per frame.
//
// Ports:
//   clk            sole clock, rising edge
//   rst_n          asynchronous active-low reset
//   i_magnitude    N unsigned bin magnitudes, held stable for the whole frame
//   i_start        frame request, sampled only while idle
//   o_bar_height   BARS registered displayed bar heights
//   o_busy         high while scanning or signalling completion
//   o_done         one-cycle pulse at frame completion
module spectrum_bar_builder #(
    parameter int unsigned WIDTH    = 12,
    parameter int unsigned N        = 256,
    parameter int unsigned BARS     = 16,
    parameter int unsigned HEIGHT_W = 5,
    parameter int unsigned SHIFT    = 8,
    parameter bit          SKIP_DC  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH+1:0]    i_magnitude  [N],
    input  logic                i_start,
    output logic [HEIGHT_W-1:0] o_bar_height [BARS],
    output logic                o_busy,
    output logic                o_done
);

    localparam int unsigned MW = WIDTH + 2;
    localparam int unsigned G  = N / BARS;
    localparam int unsigned GW = $clog2(G);
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned BW = (BARS > 1) ? $clog2(BARS) : 1;

    // Low idx bits all ones marks the last bin of a group; a mask avoids a
    // zero-width slice when G == 1.
    localparam logic [IW-1:0]       GRP_MASK = IW'(G - 1);
    localparam logic [IW-1:0]       IDX_LAST = IW'(N - 1);
    localparam logic [HEIGHT_W-1:0] HMAX     = '1;

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [IW-1:0]       r_idx;
    logic [MW-1:0]       r_grp_max;
    logic [HEIGHT_W-1:0] r_bar [BARS];

    logic [MW-1:0]       w_mag;
    logic [MW-1:0]       w_cur;
    logic [MW-1:0]       w_shifted;
    logic                w_grp_end;
    logic                w_last;
    logic [BW-1:0]       w_bar_idx;
    logic [HEIGHT_W-1:0] w_sat;
    logic [HEIGHT_W-1:0] w_dec;
    logic [HEIGHT_W-1:0] w_new;

    // Per-bin datapath: running group peak and the bar commit value.
    always_comb begin
        w_mag = i_magnitude[r_idx];
        if (SKIP_DC && (r_idx == '0)) begin
            w_mag = '0;
        end
        w_cur     = (w_mag > r_grp_max) ? w_mag : r_grp_max;
        w_grp_end = ((r_idx & GRP_MASK) == GRP_MASK);
        w_last    = (r_idx == IDX_LAST);
        w_bar_idx = BW'(r_idx >> GW);
        w_shifted = w_cur >> SHIFT;
        if (32'(w_shifted) > 32'(HMAX)) begin
            w_sat = HMAX;
        end else begin
            w_sat = HEIGHT_W'(w_shifted);
        end
        w_dec = (r_bar[w_bar_idx] == '0) ? '0 : r_bar[w_bar_idx] - 1'b1;
        w_new = (w_sat > w_dec) ? w_sat : w_dec;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: if (i_start) w_state_next = StScan;
            StScan: if (w_last) w_state_next = StDone;
            StDone: w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= '0;
            r_grp_max <= '0;
            for (int b = 0; b < int'(BARS); b++) begin
                r_bar[b] <= '0;
            end
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_idx     <= '0;
                        r_grp_max <= '0;
                    end
                end
                StScan: begin
                    if (w_grp_end) begin
                        r_bar[w_bar_idx] <= w_new;
                        r_grp_max        <= '0;
                    end else begin
                        r_grp_max <= w_cur;
                    end
                    // idx parks at the last bin rather than wrapping.
                    if (!w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int b = 0; b < int'(BARS); b++) begin
            o_bar_height[b] = r_bar[b];
        end
    end

    assign o_busy = (r_state != StIdle);
    assign o_done = (r_state == StDone);

endmodule

// File: tb/tb_spectrum_bar_builder.sv
// Directed self-checking bench for spectrum_bar_builder at default parameters.
module tb_spectrum_bar_builder;

    localparam int N    = 256;
    localparam int BARS = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [13:0] mag [N];
    logic [4:0]  bar [BARS];
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spectrum_bar_builder #(
        .WIDTH    (12),
        .N        (N),
        .BARS     (BARS),
        .HEIGHT_W (5),
        .SHIFT    (8),
        .SKIP_DC  (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_magnitude  (mag),
        .i_start      (start),
        .o_bar_height (bar),
        .o_busy       (busy),
        .o_done       (done)
    );

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clear_mags();
        for (int i = 0; i < N; i++) mag[i] = 14'd0;
    endtask

    // Pulse start (sampled at edge 0) and observe 260 cycles after it.
    task automatic run_frame(output int done_edge, output int done_cnt);
        done_edge = -1;
        done_cnt  = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 260; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_edge < 0) done_edge = k;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        clear_mags();
        mag[37] = 14'd3200;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        for (int b = 0; b < BARS; b++) begin
            checks++;
            if (bar[b] !== 5'd0) begin
                errors++; $display("FAIL reset_bar%0d got %0d want 0", b, bar[b]);
            end
        end
    endtask

    task automatic test_single_peak();
        int dn_edge = -1;
        int dn_cnt  = 0;
        clear_mags();
        mag[37] = 14'd3200;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 258; k++) begin
            @(negedge clk);
            if (done) begin
                dn_cnt++;
                if (dn_edge < 0) dn_edge = k;
            end
            if (k == 47) begin
                checks++;
                if (bar[2] !== 5'd0) begin errors++; $display("FAIL peak_bar2_pre got %0d want 0", bar[2]); end
            end
            if (k == 48) begin
                checks++;
                if (bar[2] !== 5'd12) begin errors++; $display("FAIL peak_bar2_e48 got %0d want 12", bar[2]); end
            end
            if (k == 256) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL peak_busy_e256 got %b want 1", busy); end
            end
            if (k == 257) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL peak_busy_e257 got %b want 0", busy); end
            end
        end
        checks++;
        if (dn_edge != 256) begin errors++; $display("FAIL peak_done_edge got %0d want 256", dn_edge); end
        checks++;
        if (dn_cnt != 1) begin errors++; $display("FAIL peak_done_count got %0d want 1", dn_cnt); end
        for (int b = 0; b < BARS; b++) begin
            if (b != 2) begin
                checks++;
                if (bar[b] !== 5'd0) begin errors++; $display("FAIL peak_bar%0d got %0d want 0", b, bar[b]); end
            end
        end
    endtask

    task automatic test_decay();
        int de;
        int dc;
        logic [4:0] exp_h [3];
        exp_h[0] = 5'd11; exp_h[1] = 5'd10; exp_h[2] = 5'd9;
        clear_mags();
        for (int f = 0; f < 3; f++) begin
            run_frame(de, dc);
            checks++;
            if (bar[2] !== exp_h[f]) begin
                errors++; $display("FAIL decay_frame%0d got %0d want %0d", f, bar[2], exp_h[f]);
            end
        end
        mag[40] = 14'd2560;
        run_frame(de, dc);
        checks++;
        if (bar[2] !== 5'd10) begin errors++; $display("FAIL decay_refresh got %0d want 10", bar[2]); end
        checks++;
        if (de != 256) begin errors++; $display("FAIL decay_done_edge got %0d want 256", de); end
    endtask

    task automatic test_saturation();
        int de;
        int dc;
        clear_mags();
        mag[16]  = 14'd16383;
        mag[17]  = 14'd100;
        mag[255] = 14'd511;
        run_frame(de, dc);
        checks++;
        if (bar[1] !== 5'd31) begin errors++; $display("FAIL sat_bar1 got %0d want 31", bar[1]); end
        checks++;
        if (bar[15] !== 5'd1) begin errors++; $display("FAIL sat_bar15 got %0d want 1", bar[15]); end
        checks++;
        if (bar[2] !== 5'd9) begin errors++; $display("FAIL sat_bar2_decay got %0d want 9", bar[2]); end
    endtask

    task automatic test_skip_dc();
        int de;
        int dc;
        clear_mags();
        mag[0] = 14'd16383;
        run_frame(de, dc);
        checks++;
        if (bar[0] !== 5'd0) begin errors++; $display("FAIL skipdc_bar0 got %0d want 0", bar[0]); end
        checks++;
        if (bar[15] !== 5'd0) begin errors++; $display("FAIL skipdc_bar15 got %0d want 0", bar[15]); end
        clear_mags();
        mag[1] = 14'd16383;
        run_frame(de, dc);
        checks++;
        if (bar[0] !== 5'd31) begin errors++; $display("FAIL skipdc_bin1 got %0d want 31", bar[0]); end
        checks++;
        if (bar[1] !== 5'd29) begin errors++; $display("FAIL skipdc_bar1_decay got %0d want 29", bar[1]); end
    endtask

    task automatic test_restart_ignored();
        int dn_edge = -1;
        int dn_cnt  = 0;
        clear_mags();
        mag[100] = 14'd1024;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 1; k <= 270; k++) begin
            @(negedge clk);
            if (done) begin
                dn_cnt++;
                if (dn_edge < 0) dn_edge = k;
            end
            if (k == 5 || k == 256) start = 1'b1;
            if (k == 6 || k == 257) start = 1'b0;
            if (k == 260) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy got %b want 0", busy); end
            end
        end
        checks++;
        if (dn_cnt != 1) begin errors++; $display("FAIL restart_done_count got %0d want 1", dn_cnt); end
        checks++;
        if (dn_edge != 256) begin errors++; $display("FAIL restart_done_edge got %0d want 256", dn_edge); end
        checks++;
        if (bar[6] !== 5'd4) begin errors++; $display("FAIL restart_bar6 got %0d want 4", bar[6]); end
    endtask

    task automatic test_reset_midframe();
        int de;
        int dc;
        int stray = 0;
        int nz = 0;
        clear_mags();
        mag[20] = 14'd4096;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int b = 0; b < BARS; b++) if (bar[b] !== 5'd0) nz++;
        checks++;
        if (nz != 0) begin errors++; $display("FAIL midrst_bars got %0d nonzero want 0", nz); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL midrst_idle got %0d active cycles want 0", stray); end
        clear_mags();
        mag[200] = 14'd2048;
        run_frame(de, dc);
        checks++;
        if (de != 256) begin errors++; $display("FAIL midrst_done_edge got %0d want 256", de); end
        checks++;
        if (dc != 1) begin errors++; $display("FAIL midrst_done_count got %0d want 1", dc); end
        checks++;
        if (bar[12] !== 5'd8) begin errors++; $display("FAIL midrst_bar12 got %0d want 8", bar[12]); end
        checks++;
        if (bar[1] !== 5'd0) begin errors++; $display("FAIL midrst_bar1 got %0d want 0", bar[1]); end
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_decay();
        test_saturation();
        test_skip_dc();
        test_restart_ignored();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_builder.md
# spectrum_bar_builder

Sequential consumer of the per-bin magnitude array produced by the complex magnitude estimator. On each frame request it scans all N magnitude bins, one per clock, takes the peak magnitude within each group of N/BARS consecutive bins, and scales and saturates that peak into a display bar height. Displayed bars use peak-hold with a linear decay of 1 per frame. It sits between the magnitude stage and the display/LED renderer.

## Interface
- WIDTH, 12, magnitude input is WIDTH+2 bits wide, matching the estimator output
- N, 256, number of bins; power of 2
- BARS, 16, number of output bars; power of 2; BARS <= N
- HEIGHT_W, 5, bar height width; HMAX = 2^HEIGHT_W-1
- SHIFT, 8, right shift applied to group peak before saturation
- SKIP_DC, 1, when 1 bin 0 is treated as magnitude 0
- clk  input  1  sole clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- magnitude  input  [WIDTH+1:0] x [0:N-1]  unsigned bin magnitudes; must be held stable from start accept until done
- start  input  1  frame request; sampled only in IDLE
- bar_height  output  [HEIGHT_W-1:0] x [0:BARS-1]  registered displayed bar heights
- busy  output  1  high in SCAN and DONE
- done  output  1  one-cycle pulse at frame completion

## Operation
- G = N/BARS bins per group. Index register idx is $clog2(N) bits wide. Group peak register grp_max is WIDTH+2 bits wide.
- FSM states are IDLE, SCAN and DONE.
- IDLE
  - On start=1: go to SCAN, idx<=0, grp_max<=0.
  - Otherwise hold.
- SCAN, each cycle:
  - m = magnitude[idx]; if SKIP_DC and idx==0, m=0.
  - cur = max(grp_max, m).
  - If idx[log2 G - 1:0] is all ones, the group ends:
    - commit bar b = idx >> log2(G) using cur;
    - grp_max <= 0.
  - Otherwise grp_max <= cur.
  - idx <= idx+1.
  - When idx==N-1: go to DONE.
- Commit rule for bar b:
  - s = cur >> SHIFT;
  - sat = (s > HMAX) ? HMAX : s;
  - dec = (bar_height[b]==0) ? 0 : bar_height[b]-1;
  - bar_height[b] <= max(sat, dec).
- DONE: done=1 for exactly this cycle, then go to IDLE.
- start while busy (SCAN or DONE) is ignored. It is not queued.
- Only bars whose group has completed have updated values mid-frame. All bars are final once done is high.
- All comparisons are unsigned. Nothing wraps: idx stops at N-1 and the FSM leaves SCAN.

## Timing
- Reset values:
  - FSM = IDLE;
  - idx = 0;
  - grp_max = 0;
  - every bar_height = 0;
  - busy = 0;
  - done = 0.
- Reset asserted mid-frame aborts immediately:
  - bars clear to 0;
  - no done pulse is produced;
  - after release the block waits in IDLE for a new start.
- Latency, counting the edge that samples start as edge 0:
  - SCAN occupies edges 1..N;
  - bar b updates at edge (b+1)*G;
  - done is high during the cycle after edge N;
  - busy falls at edge N+1.
- Back-to-back frames: start may be asserted in the cycle done is high, but is ignored. The earliest accepted start is the next cycle, IDLE. Minimum frame period is N+2 cycles.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Defaults throughout (N=256, BARS=16, G=16, SHIFT=8, HEIGHT_W=5).
- Reset, then idle 10 cycles -> all bar_height=0, busy=0, done=0; start while in reset has no effect.
- All magnitude=0 except magnitude[37]=3200, one start -> bar_height[2]=12 (3200>>8) updated at edge 48, all others 0; done high exactly in the cycle after edge 256, busy low after edge 257.
- magnitude[16]=16383, magnitude[17]=100 -> bar_height[1]=31 (63 saturated); magnitude[255]=511 in the same frame -> bar_height[15]=1.
- Decay: after a frame leaving bar_height[2]=12, run three all-zero frames -> 11, 10, 9. Then a frame with magnitude[40]=2560 -> bar_height[2]=10 (max(10, 8)).
- SKIP_DC: magnitude[0]=16383, all others 0 -> bar_height[0]=0. Then magnitude[1]=16383 -> bar_height[0]=31.
- Re-pulse start at cycles 5 and 256 of a scan -> done pulses once, frame unaffected. A new frame with reset asserted at cycle 100 -> all bars 0 immediately, no done; a fresh start after release completes normally in N+1 cycles.
